pipe_addsub: RTL

//  Parametrised, pipelined WIDTH-bit adder/subtractor built from 4-bit carry-lookahead slices.

---
 rtl/pipe_addsub_pkg.sv | 9 +
 rtl/add_slice4.sv | 29 ++
 rtl/pipe_addsub.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared types for the pipelined carry-lookahead adder/subtractor.
package pipe_addsub_pkg;
  localparam int SLICE_W = 4;
  typedef logic [SLICE_W-1:0] slice_t;
  typedef struct packed {
    slice_t s;
    logic   c;
  } slice_res_t;
endpackage

// File: rtl/add_slice4.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3 for overflow detection.
module add_slice4
  import pipe_addsub_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   ci,
  output slice_t q,
  output logic   co,
  output logic   c3
);
  slice_t     g, p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is flattened onto g/p/ci so no carry depends on another.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign q  = p ^ c[3:0];
  assign co = c[4];
  assign c3 = c[3];
endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/sub, one slice group per stage with registered inter-stage carry.
// Define PIPE_ADDSUB_SAT_EN to clamp q on signed overflow in the final stage.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             ov
);
  localparam int GW     = SLICE_W * SLICES_PER_STAGE;
  localparam int STAGES = WIDTH / GW;

  // acc_r[k] holds finished result bits below group k+1 and untouched A bits above.
  // bs_r[k] holds remaining B groups shifted down so the next group sits at bit 0.
  logic [STAGES-1:0] vld_pipe;
  logic [STAGES:0]   adv;
  logic [WIDTH-1:0]  acc_r   [STAGES];
  logic [WIDTH-1:0]  bs_r    [STAGES];
  logic              c_r     [STAGES];
  logic              ov_r;

  logic [WIDTH-1:0]  src_acc [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic              src_c   [STAGES];
  logic              src_v   [STAGES];
  logic [WIDTH-1:0]  nxt_acc [STAGES];
  logic [GW-1:0]     grp_q   [STAGES];
  logic              grp_co  [STAGES];
  logic              grp_c3  [STAGES];
  logic              ov_n;

  always_comb begin
    src_acc[0] = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = ci;
    src_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_acc[k] = acc_r[k-1];
      src_b[k]   = bs_r[k-1];
      src_c[k]   = c_r[k-1];
      src_v[k]   = vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : g_sl
      logic       sci;
      slice_res_t r;
      logic       c3;
      if (j == 0) begin : g_c0
        assign sci = src_c[k];
      end else begin : g_cn
        assign sci = g_sl[j-1].r.c;
      end
      add_slice4 u_sl (
        .a  (src_acc[k][k*GW + j*SLICE_W +: SLICE_W]),
        .b  (src_b[k][j*SLICE_W +: SLICE_W]),
        .ci (sci),
        .q  (r.s),
        .co (r.c),
        .c3 (c3)
      );
      assign grp_q[k][j*SLICE_W +: SLICE_W] = r.s;
    end
    assign grp_co[k] = g_sl[SLICES_PER_STAGE-1].r.c;
    assign grp_c3[k] = g_sl[SLICES_PER_STAGE-1].c3;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_acc[k]             = src_acc[k];
      nxt_acc[k][k*GW +: GW] = grp_q[k];
    end
    ov_n = grp_c3[STAGES-1] ^ grp_co[STAGES-1];
`ifdef PIPE_ADDSUB_SAT_EN
    // A wrong-signed result means the true value lies beyond the opposite rail.
    if (ov_n)
      nxt_acc[STAGES-1] = nxt_acc[STAGES-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                      : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES-1; k >= 0; k--)
      adv[k] = ~vld_pipe[k] | adv[k+1];
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      vld_pipe <= '0;
      ov_r     <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_r[k] <= '0;
        bs_r[k]  <= '0;
        c_r[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= src_v[k];
          acc_r[k]    <= nxt_acc[k];
          bs_r[k]     <= src_b[k] >> GW;
          c_r[k]      <= grp_co[k];
        end
      end
      if (adv[STAGES-1])
        ov_r <= ov_n;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_pipe[STAGES-1];
  assign q         = acc_r[STAGES-1];
  assign co        = c_r[STAGES-1];
  assign ov        = ov_r;
endmodule
